traffic_phase_controller: RTL and testbench
===========================================

// Module: traffic_phase_controller
// PURPOSE
//  Sequences a three-lamp signal RED -> GREEN -> YELLOW -> RED, with a programmable dwell per phase counted in tick strobes.
//  Serves pedestrian requests by shortening GREEN to a minimum and granting a WALK interval during RED.
//  Sits between a tick prescaler and the lamp drivers.
//  Lamp encoding is one-hot over [0:2]: RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
// PARAMETERS
//  RED_TICKS     8  RED dwell in ticks (>=1; elaboration error otherwise)
//  GREEN_TICKS   6  GREEN dwell in ticks with no pedestrian request pending (>=MIN_GREEN)
//  YELLOW_TICKS  2  YELLOW dwell in ticks (>=1)
//  MIN_GREEN     2  minimum GREEN ticks before a pending request may cut GREEN short (>=1)
//  CNT_W         8  dwell counter width; every *_TICKS value must fit in it
//  FLASH_HALF    4  ticks per half-period of flashing yellow (only with FLASH_MODE_EN)
// PORTS
//  clock     in   1  single clock; all state updates on posedge
//  reset_n   in   1  synchronous, active-low reset
//  tick      in   1  one-cycle advance strobe; the dwell counter moves only when tick=1
//  ped_req   in   1  pedestrian request level; may be held or pulsed
//  ped_ack   out  1  one-cycle pulse; a pending request has been granted
//  walk      out  1  high for the whole RED phase that serves a request
//  light     out  [0:2] registered one-hot lamp drive
//  phase     out  2  current state: 0 RED, 1 GREEN, 2 YELLOW, 3 FLASH
//  flash     in   1  force flashing-yellow mode (port exists only with FLASH_MODE_EN)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    - phase=RED, cnt=0, light=100, walk=0, ped_ack=0, pending=0.
//    - Reset asserted mid-phase aborts that phase immediately; any pending request is discarded.
//  - State and light are registered together, so light always matches phase with no extra cycle of latency.
//  - Dwell, evaluated only on cycles with tick=1:
//    - If cnt==DUR(phase)-1: advance to the next phase and set cnt=0.
//    - Otherwise cnt=cnt+1.
//    - Net effect: each phase lasts exactly DUR ticks.
//  - Transitions:
//    - RED -> GREEN; walk drops on this edge.
//    - GREEN -> YELLOW when the dwell expires, or on a tick with pending=1 and cnt>=MIN_GREEN-1.
//    - YELLOW -> RED. If pending=1 at this transition: ped_ack=1 for that one cycle, pending cleared, walk=1 for the whole RED.
//  - pending is set on any cycle with ped_req=1 except the cycle in which ped_ack is driven.
//    - ped_req during the ack cycle is ignored; a requester that still holds ped_req re-sets pending on the next cycle.
//    - A request arriving during RED is served at the following YELLOW->RED transition, not the current RED.
//  - tick=0: all state holds. A pending request never forces a transition without a tick.
//  - Encoding phase=3 without FLASH_MODE_EN is unreachable; if it is ever entered, the next clock forces RED, cnt=0.
// CONFIGURATION
//  FLASH_MODE_EN defined:
//    - Adds the flash port.
//    - flash=1 at a posedge moves to FLASH on that edge, whatever the phase or tick: cnt=0, walk=0, light=001.
//    - In FLASH, light toggles 001 <-> 000 every FLASH_HALF ticks; pending is retained.
//    - flash=0 exits to RED with cnt=0. A retained pending request is served at the next YELLOW->RED.
//  FLASH_MODE_EN undefined: no flash port, no FLASH logic; FLASH_HALF is unused.
// STRUCTURE
//  - traffic_pkg holds:
//    - phase_t enum (RED, GREEN, YELLOW, FLASH)
//    - lamp constants LAMP_RED, LAMP_GREEN, LAMP_YELLOW, LAMP_OFF
//    - function lamp_of(phase_t)
//  - Sub-module dwell_counter (CNT_W):
//    - inputs clock, reset_n, tick, clear, dur
//    - outputs cnt, last (cnt==dur-1)
//  - The FSM, pending/ack logic and the light register stay in this module.
// TESTING (defaults; tick=1 every cycle unless stated)
//  - Free run from reset, no requests:
//    RED for cycles 0-7, GREEN 8-13, YELLOW 14-15, RED again at 16; period 16; walk=0; ped_ack never asserted.
//  - One-cycle ped_req pulse at the first GREEN cycle:
//    GREEN lasts 2 cycles; YELLOW 2; at RED entry ped_ack=1 for 1 cycle; walk=1 for the 8 RED cycles, then 0.
//  - ped_req held high continuously:
//    ack exactly once per cycle of phases; GREEN always 2 ticks; walk high during every RED.
//  - tick every 3rd cycle: every phase duration scales by 3 (RED=24 cycles); a request raised between ticks changes nothing until the next tick.
//  - reset_n=0 for 1 cycle during GREEN with pending=1:
//    next cycle light=100, phase=0, walk=0; no ped_ack until a fresh request is served.
//  - FLASH_MODE_EN build, flash=1 for 20 cycles starting mid-GREEN:
//    light 001 for 4 cycles, 000 for 4, repeating; after flash=0, RED lasts 8 ticks.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and lamp constants for the traffic phase controller.
//   phase_t  : controller phase, encoded 0 RED, 1 GREEN, 2 YELLOW, 3 FLASH
//   LAMP_*   : one-hot lamp drive patterns over [0:2] (RED=100, GREEN=010, YELLOW=001)
//   lamp_of  : lamp pattern shown while steady in a given phase
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } phase_t;

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;
  localparam logic [0:2] LAMP_OFF    = 3'b000;

  // FLASH starts on the yellow half of its blink cycle.
  function automatic logic [0:2] lamp_of(input phase_t p);
    case (p)
      RED:     lamp_of = LAMP_RED;
      GREEN:   lamp_of = LAMP_GREEN;
      default: lamp_of = LAMP_YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Tick-driven dwell counter for one traffic phase.
//   clock   : posedge clock
//   reset_n : synchronous active-low reset (cnt -> 0)
//   tick    : advance strobe; cnt moves only when tick=1
//   clear   : forces cnt to 0 on the next edge regardless of tick
//   dur     : dwell length of the current phase in ticks (>=1)
//   cnt     : ticks already spent in the current phase
//   last    : cnt is on the final tick of the dwell (cnt == dur-1)
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == (dur - CNT_W'(1)));

  // The counter wraps to 0 by itself on the last tick, so the controller only
  // needs clear for transitions that do not coincide with the dwell expiring.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Three-lamp signal sequencer RED -> GREEN -> YELLOW -> RED with per-phase
// dwell counted in tick strobes and pedestrian request service.
//   clock   : posedge clock
//   reset_n : synchronous active-low reset
//   tick    : one-cycle advance strobe from the prescaler
//   ped_req : pedestrian request level (held or pulsed)
//   flash   : force flashing yellow (only when FLASH_MODE_EN is defined)
//   ped_ack : one-cycle pulse, a pending request has been granted
//   walk    : high for the whole RED phase that serves a request
//   light   : registered one-hot lamp drive [0:2]
//   phase   : current FSM state (0 RED, 1 GREEN, 2 YELLOW, 3 FLASH)
// Build option: define FLASH_MODE_EN to add the flash port and FLASH phase.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int RED_TICKS    = 8,
  parameter int GREEN_TICKS  = 6,
  parameter int YELLOW_TICKS = 2,
  parameter int MIN_GREEN    = 2,
  parameter int CNT_W        = 8,
  parameter int FLASH_HALF   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       ped_req,
`ifdef FLASH_MODE_EN
  input  logic       flash,
`endif
  output logic       ped_ack,
  output logic       walk,
  output logic [0:2] light,
  output logic [1:0] phase
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (RED_TICKS < 1 || YELLOW_TICKS < 1 || MIN_GREEN < 1 || FLASH_HALF < 1 ||
      GREEN_TICKS < MIN_GREEN || RED_TICKS > CNT_MAX || GREEN_TICKS > CNT_MAX ||
      YELLOW_TICKS > CNT_MAX || FLASH_HALF > CNT_MAX) begin : g_bad_cfg
    $error("traffic_phase_controller: dwell parameters out of range");
  end

  localparam logic [CNT_W-1:0] D_RED    = CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] D_GREEN  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] MIN_CUT  = CNT_W'(MIN_GREEN - 1);
`ifdef FLASH_MODE_EN
  localparam logic [CNT_W-1:0] D_FLASH  = CNT_W'(FLASH_HALF);
`endif

  phase_t           state;
  logic             pending;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             clear;
  logic             green_cut;

  assign phase = state;

  // A pending request may end GREEN early once the minimum has been served.
  assign green_cut = pending && (cnt >= MIN_CUT);

  always_comb begin
    dur = D_RED;
    case (state)
      GREEN:   dur = D_GREEN;
      YELLOW:  dur = D_YELLOW;
`ifdef FLASH_MODE_EN
      FLASH:   dur = D_FLASH;
`endif
      default: dur = D_RED;
    endcase
  end

  always_comb begin
    clear = 1'b0;
    case (state)
      GREEN:       clear = tick && green_cut;
      RED, YELLOW: clear = 1'b0;
`ifdef FLASH_MODE_EN
      default:     clear = !flash;   // leaving FLASH starts RED from zero
`else
      default:     clear = 1'b1;     // stray encoding recovers to RED, cnt=0
`endif
    endcase
`ifdef FLASH_MODE_EN
    if (flash && state != FLASH) clear = 1'b1;
`endif
  end

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .clear   (clear),
    .dur     (dur),
    .cnt     (cnt),
    .last    (last)
  );

  // Pedestrian handshake: ped_req is a level sampled every cycle into pending;
  // ped_ack is a single-cycle grant issued on the YELLOW->RED edge that serves
  // pending. ped_req seen during the ack cycle is dropped, so a held request
  // re-arms pending one cycle later and is served on the next round.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= RED;
      light   <= LAMP_RED;
      walk    <= 1'b0;
      ped_ack <= 1'b0;
      pending <= 1'b0;
    end else begin
      ped_ack <= 1'b0;
      if (ped_req && !ped_ack) pending <= 1'b1;
`ifdef FLASH_MODE_EN
      if (flash) begin
        walk <= 1'b0;
        if (state != FLASH) begin
          state <= FLASH;
          light <= LAMP_YELLOW;
        end else if (tick && last) begin
          light <= (light == LAMP_OFF) ? LAMP_YELLOW : LAMP_OFF;
        end
      end else if (state == FLASH) begin
        state <= RED;
        light <= LAMP_RED;
      end else
`endif
      case (state)
        RED: begin
          if (tick && last) begin
            state <= GREEN;
            light <= lamp_of(GREEN);
            walk  <= 1'b0;
          end
        end
        GREEN: begin
          if (tick && (last || green_cut)) begin
            state <= YELLOW;
            light <= lamp_of(YELLOW);
          end
        end
        YELLOW: begin
          if (tick && last) begin
            state <= RED;
            light <= lamp_of(RED);
            if (pending) begin
              ped_ack <= 1'b1;
              pending <= 1'b0;
              walk    <= 1'b1;
            end
          end
        end
        default: begin
          state <= RED;
          light <= LAMP_RED;
          walk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

  localparam int RED_T    = 8;
  localparam int GREEN_T  = 6;
  localparam int YELLOW_T = 2;
  localparam int MIN_G    = 2;

  localparam logic [1:0] P_RED    = 2'd0;
  localparam logic [1:0] P_GREEN  = 2'd1;
  localparam logic [1:0] P_YELLOW = 2'd2;
  localparam logic [1:0] P_FLASH  = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick    = 1'b0;
  logic       ped_req = 1'b0;
`ifdef FLASH_MODE_EN
  logic       flash   = 1'b0;
`endif
  logic       ped_ack;
  logic       walk;
  logic [0:2] light;
  logic [1:0] phase;

  always #5 clock = ~clock;

  traffic_phase_controller dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .ped_req (ped_req),
`ifdef FLASH_MODE_EN
    .flash   (flash),
`endif
    .ped_ack (ped_ack),
    .walk    (walk),
    .light   (light),
    .phase   (phase)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- helpers / driver ----------------
  function automatic logic [0:2] lamp(input logic [1:0] p);
    case (p)
      2'd0:    lamp = 3'b100;
      2'd1:    lamp = 3'b010;
      2'd2:    lamp = 3'b001;
      default: lamp = 3'b000;
    endcase
  endfunction

  task automatic check_out(input string name, input logic [1:0] eph,
                           input logic [0:2] elt, input logic ew, input logic ea);
    checks++;
    if ({phase, light, walk, ped_ack} !== {eph, elt, ew, ea}) begin
      errors++;
      $display("FAIL %s t=%0t: got phase=%0d light=%b walk=%b ack=%b, expected phase=%0d light=%b walk=%b ack=%b",
               name, $time, phase, light, walk, ped_ack, eph, elt, ew, ea);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Drive inputs just after an edge, then observe 1 time unit after the next edge.
  task automatic step(input logic r, input logic t, input logic q);
    reset_n = r;
    tick    = t;
    ped_req = q;
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst_n;
    logic       tk;
    logic       req;
    int         reps;
    logic [1:0] ph;
    logic       w;
    logic       a;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic r, input logic t, input logic q, input int n,
                              input logic [1:0] ph, input logic w, input logic a);
    vec_t v;
    v.rst_n = r; v.tk = t; v.req = q; v.reps = n; v.ph = ph; v.w = w; v.a = a;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  int  dur_tbl[3] = '{RED_T, GREEN_T, YELLOW_T};
  int  m_ph, m_el;
  bit  m_pend, m_walk, m_ack;
  logic [6:0] exp_q[$];

  // Phase index + ticks elapsed in phase; a phase ends after dur ticks, or
  // GREEN ends after MIN_G ticks when a request was already pending.
  function automatic void model_step(input bit r, input bit t, input bit q);
    bit npend, nack, leave;
    int e;
    if (!r) begin
      m_ph = 0; m_el = 0; m_pend = 0; m_walk = 0; m_ack = 0;
      return;
    end
    npend = m_pend | (q & ~m_ack);
    nack  = 1'b0;
    if (t) begin
      e = m_el + 1;
      leave = (e == dur_tbl[m_ph]) || (m_ph == 1 && m_pend && e >= MIN_G);
      if (leave) begin
        m_ph = (m_ph + 1) % 3;
        m_el = 0;
        if (m_ph == 0) begin
          m_walk = m_pend;
          if (m_pend) begin nack = 1'b1; npend = 1'b0; end
        end else if (m_ph == 1) begin
          m_walk = 1'b0;
        end
      end else begin
        m_el = e;
      end
    end
    m_pend = npend;
    m_ack  = nack;
  endfunction

  // ---------------- run-length recorder ----------------
  typedef struct packed { logic [1:0] ph; logic w; logic a; } rec_t;
  rec_t rec[$];

  task automatic record_run(input int n, input int div, input logic q);
    rec.delete();
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i % div) == 0, q);
      rec.push_back({phase, walk, ped_ack});
    end
  endtask

  // Check every complete run (first and last may be partial).
  task automatic check_runs(input string name, input int div, input int green_len,
                            input bit expect_walk);
    int starts[$];
    int acks, red_entries;
    starts.push_back(0);
    for (int i = 1; i < rec.size(); i++)
      if (rec[i].ph != rec[i-1].ph) starts.push_back(i);
    for (int k = 1; k + 1 < starts.size(); k++) begin
      int s, len, exp_len;
      logic wall;
      s = starts[k];
      len = starts[k+1] - s;
      case (rec[s].ph)
        P_RED:    exp_len = RED_T * div;
        P_GREEN:  exp_len = green_len * div;
        default:  exp_len = YELLOW_T * div;
      endcase
      check_int($sformatf("%s_len_ph%0d_run%0d", name, rec[s].ph, k), len, exp_len);
      if (rec[s].ph == P_RED) begin
        wall = 1'b1;
        for (int i = s; i < s + len; i++) wall &= rec[i].w;
        check_int($sformatf("%s_walk_run%0d", name, k), int'(wall), int'(expect_walk));
        check_int($sformatf("%s_ack_entry%0d", name, k), int'(rec[s].a), int'(expect_walk));
      end
    end
    acks = 0;
    red_entries = 0;
    for (int i = 1; i < rec.size(); i++) begin
      if (rec[i].a) acks++;
      if (rec[i].ph == P_RED && rec[i-1].ph != P_RED) red_entries++;
    end
    check_int({name, "_ack_count"}, acks, expect_walk ? red_entries : 0);
  endtask

  // ---------------- test ----------------
  initial begin
    // Free run from reset.
    add(0, 1, 0, 1, P_RED,    0, 0);
    add(1, 1, 0, 7, P_RED,    0, 0);
    add(1, 1, 0, 6, P_GREEN,  0, 0);
    add(1, 1, 0, 2, P_YELLOW, 0, 0);
    add(1, 1, 0, 8, P_RED,    0, 0);
    // One-cycle pulse at the first GREEN cycle.
    add(1, 1, 0, 1, P_GREEN,  0, 0);
    add(1, 1, 1, 1, P_GREEN,  0, 0);
    add(1, 1, 0, 2, P_YELLOW, 0, 0);
    add(1, 1, 0, 1, P_RED,    1, 1);
    add(1, 1, 0, 7, P_RED,    1, 0);
    // Request raised between ticks early in GREEN.
    add(1, 1, 0, 1, P_GREEN,  0, 0);
    add(1, 0, 1, 3, P_GREEN,  0, 0);
    add(1, 1, 0, 1, P_GREEN,  0, 0);
    add(1, 1, 0, 2, P_YELLOW, 0, 0);
    add(1, 1, 0, 1, P_RED,    1, 1);
    // No tick: RED holds, ack still a single cycle.
    add(1, 0, 0, 4, P_RED,    1, 0);
    add(1, 1, 0, 7, P_RED,    1, 0);
    // Reset during GREEN with a request pending discards it.
    add(1, 1, 1, 1, P_GREEN,  0, 0);
    add(0, 1, 0, 1, P_RED,    0, 0);
    add(1, 1, 0, 7, P_RED,    0, 0);
    add(1, 1, 0, 6, P_GREEN,  0, 0);
    add(1, 1, 0, 2, P_YELLOW, 0, 0);
    add(1, 1, 0, 1, P_RED,    0, 0);

    foreach (vecs[k])
      for (int j = 0; j < vecs[k].reps; j++) begin
        step(vecs[k].rst_n, vecs[k].tk, vecs[k].req);
        check_out($sformatf("vec%0d_%0d", k, j), vecs[k].ph, lamp(vecs[k].ph), vecs[k].w, vecs[k].a);
      end

    // Held request: GREEN always MIN_G, every RED walks and is acked once.
    step(1'b0, 1'b1, 1'b0);
    record_run(80, 1, 1'b1);
    check_runs("held_req", 1, MIN_G, 1'b1);

    // Tick every third cycle scales every dwell by 3.
    step(1'b0, 1'b1, 1'b0);
    record_run(200, 3, 1'b0);
    check_runs("tick_div3", 3, GREEN_T, 1'b0);

`ifdef FLASH_MODE_EN
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    check_out("flash_pre_green", P_GREEN, lamp(P_GREEN), 1'b0, 1'b0);
    flash = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check_out($sformatf("flash_%0d", i), P_FLASH,
                (((i / 4) % 2) == 0) ? 3'b001 : 3'b000, 1'b0, 1'b0);
    end
    flash = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check_out($sformatf("flash_exit_red%0d", i), P_RED, lamp(P_RED), 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    check_out("flash_exit_green", P_GREEN, lamp(P_GREEN), 1'b0, 1'b0);
`endif

    // Randomized stimulus against the reference model.
    model_step(1'b0, 1'b1, 1'b0);
    exp_q.push_back({2'(m_ph), lamp(2'(m_ph)), m_walk, m_ack});
    step(1'b0, 1'b1, 1'b0);
    begin
      logic [6:0] e;
      e = exp_q.pop_front();
      check_out("rand_reset", e[6:5], e[4:2], e[1], e[0]);
    end
    for (int blk = 0; blk < 15; blk++) begin
      int div;
      div = $urandom_range(1, 3);
      for (int i = 0; i < 200; i++) begin
        logic r, t, q;
        logic [6:0] e;
        r = ($urandom_range(0, 199) != 0);
        t = ($urandom_range(1, div) == 1);
        q = ($urandom_range(0, 5) == 0);
        model_step(r, t, q);
        exp_q.push_back({2'(m_ph), lamp(2'(m_ph)), m_walk, m_ack});
        step(r, t, q);
        e = exp_q.pop_front();
        check_out($sformatf("rand_b%0d_c%0d", blk, i), e[6:5], e[4:2], e[1], e[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
